processor_top: RTL and testbench
================================

Name: processor_top

Overview:
- Board-level top of the MP4 LED image. It drives the on-board RGB LED with three sine-modulated PWM channels, each offset a quarter-period in phase, and a heartbeat blink on the user LED.
- Contains a free-running PWM counter, a phase accumulator, a 65-entry quarter-wave sine table with symmetry decode, per-channel duty registers, and a blink divider.
- There are no handshakes; all outputs are free-running.

Parameters:
- PWM_BITS, 8: PWM counter and duty width. Behaviour below is specified for 8.
- STEP_DIV, 1: number of full PWM periods per phase increment (≥1).
- BLINK_DIV, 1024: clock cycles between LED toggles (≥1).

Ports:
- clk, input, 1: single system clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- RGB_R, output, 1: red channel, active-low (0 = lit).
- RGB_G, output, 1: green channel, active-low.
- RGB_B, output, 1: blue channel, active-low.
- LED, output, 1: heartbeat, active-high.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following take effect immediately and hold while rst_n=0.
  - cnt=0, phase=0, step=0, blink counter=0.
  - LED=0; RGB_R/G/B=1 (all off).
  - Duty registers load their phase-0 values: dR=128, dG=255, dB=1.
- PWM counter cnt: 8-bit, increments every cycle, wraps 255→0. PWM period is 256 cycles.
- Channel phases: pR=phase, pG=phase+64, pB=phase+192, all mod 256.
- Sine function S(p), p 8-bit:
  - Decode: quadrant=p[7:6], i=p[5:0].
  - Quadrant 0: 128+Q[i]. Quadrant 1: 128+Q[64-i]. Quadrant 2: 128-Q[i]. Quadrant 3: 128-Q[64-i].
  - Q[k]=round(127·sin(2πk/256)) for k=0..64, rounding half up. Q[0]=0, Q[32]=90, Q[64]=127.
  - Range of S is 1..255. Key values: S(0)=128, S(64)=255, S(128)=128, S(192)=1.
  - Table is combinational (case ROM); no read latency.
- Phase stepping:
  - On a cycle where cnt==255, step increments.
  - When step reaches STEP_DIV, it clears to 0 and phase increments (wraps 255→0).
- Duty registers:
  - Load on the cycle where cnt==255, taking S() of each channel phase using the phase value in effect after that edge.
  - The new duties apply from the following cnt==0 onward; there is no duty change mid-period.
- Output drive:
  - RGB_x registered: RGB_x <= ~(cnt_next < dX), where cnt_next is the counter value after the edge.
  - Net effect: the output is low for exactly dX cycles starting at cnt==0 of each period.
  - Duty 255 leaves a single high cycle per period. A full-on duty of 256 is unreachable.
- LED: a counter counts clock cycles. On reaching BLINK_DIV it clears and LED toggles. Period is 2·BLINK_DIV cycles.
- Reset mid-operation: instantly returns every register to its reset value. The first cycle after release has cnt=0.
- Simultaneous events: phase wrap, step wrap and blink toggle on the same edge are independent and all take effect.

Test Plan:
- Reset check: hold rst_n=0 for 5 cycles → RGB_R=RGB_G=RGB_B=1, LED=0. Assert rst_n=0 mid-run → outputs return to those values without waiting for a clock.
- First PWM period after release (cnt 0..255):
  - RGB_R low for 128 cycles, then high 128.
  - RGB_G low 255, then high 1.
  - RGB_B low 1, then high 255.
- Heartbeat: with BLINK_DIV=1024, LED rises exactly 1024 cycles after release and falls at 2048. Run 5000 cycles → 4 toggles.
- Phase sweep (STEP_DIV=1): count low cycles of RGB_R per period.
  - Period 0 → 128; period 32 → 218; period 64 → 255; period 128 → 128; period 192 → 1.
  - Period 256 → 128 (wrap).
- Channel offset: in every period, dG equals dR of the period 64 later, and dB equals dR of the period 192 later. Check over 512 periods.
- STEP_DIV=4: dR stays 128 for periods 0..3 and changes only at period 4. No mid-period output edge other than the single on→off transition.

Source files
------------

// File: rtl/processor_top.sv
// processor_top: MP4 LED image top, three quarter-phase sine PWM channels plus heartbeat blink
// clk   : system clock, all state on the rising edge
// rst_n : asynchronous active-low reset
// RGB_R/RGB_G/RGB_B : active-low PWM drive for the RGB LED
// LED   : active-high heartbeat, toggles every BLINK_DIV cycles
module processor_top #(
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 1,
  parameter int BLINK_DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B,
  output logic LED
);
  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [PWM_BITS-1:0] cnt_q, cnt_d, dr_q, dr_d, dg_q, dg_d, db_q, db_d;
  logic [7:0] phase_q, phase_d;
  logic [SW-1:0] step_q, step_d, step_inc;
  logic [BW-1:0] blk_q, blk_d, blk_inc;
  logic r_q, r_d, g_q, g_d, b_q, b_d, led_q, led_d;
  logic wrap, step_hit, blk_hit;
  // round(127*sin(2*pi*k/256)), k = 0..64
  function automatic logic [6:0] qtab(input logic [6:0] k);
    logic [6:0] q;
    case (k)
      7'd0: q = 7'd0;    7'd1: q = 7'd3;    7'd2: q = 7'd6;    7'd3: q = 7'd9;
      7'd4: q = 7'd12;   7'd5: q = 7'd16;   7'd6: q = 7'd19;   7'd7: q = 7'd22;
      7'd8: q = 7'd25;   7'd9: q = 7'd28;   7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction
  // odd quadrants mirror the index, upper half negates the offset around 128
  function automatic logic [7:0] sine(input logic [7:0] p);
    logic [6:0] k;
    logic [6:0] q;
    k = p[6] ? 7'd64 - {1'b0, p[5:0]} : {1'b0, p[5:0]};
    q = qtab(k);
    return p[7] ? 8'd128 - {1'b0, q} : 8'd128 + {1'b0, q};
  endfunction
  always_comb begin
    wrap     = &cnt_q;
    cnt_d    = cnt_q + PWM_BITS'(1);
    step_inc = step_q + SW'(1);
    step_hit = wrap && (step_inc == SW'(STEP_DIV));
    step_d   = wrap ? (step_hit ? '0 : step_inc) : step_q;
    phase_d  = step_hit ? phase_q + 8'd1 : phase_q;
    // duties sample the post-edge phase so the new period starts with fresh values
    dr_d     = wrap ? PWM_BITS'(sine(phase_d)) : dr_q;
    dg_d     = wrap ? PWM_BITS'(sine(phase_d + 8'd64)) : dg_q;
    db_d     = wrap ? PWM_BITS'(sine(phase_d + 8'd192)) : db_q;
    r_d      = ~(cnt_d < dr_d);
    g_d      = ~(cnt_d < dg_d);
    b_d      = ~(cnt_d < db_d);
    blk_inc  = blk_q + BW'(1);
    blk_hit  = blk_inc == BW'(BLINK_DIV);
    blk_d    = blk_hit ? '0 : blk_inc;
    led_d    = blk_hit ? ~led_q : led_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
      step_q  <= '0;
      blk_q   <= '0;
      dr_q    <= PWM_BITS'(128);
      dg_q    <= PWM_BITS'(255);
      db_q    <= PWM_BITS'(1);
      r_q     <= 1'b1;
      g_q     <= 1'b1;
      b_q     <= 1'b1;
      led_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      blk_q   <= blk_d;
      dr_q    <= dr_d;
      dg_q    <= dg_d;
      db_q    <= db_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      led_q   <= led_d;
    end
  end
  assign RGB_R = r_q;
  assign RGB_G = g_q;
  assign RGB_B = b_q;
  assign LED   = led_q;
endmodule

// File: tb/tb_processor_top.sv
// tb_processor_top: scoreboard bench comparing per-period PWM low counts and heartbeat against a sine model
module tb_processor_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r1, g1, b1, led1, r4, g4, b4, led4;
  int checks = 0;
  int errors = 0;
  typedef struct {int r; int g; int b;} exp_t;
  exp_t q1[$];
  int q4[$];
  localparam int NP1 = 270;
  localparam int NP2 = 12;
  processor_top dut1 (.clk(clk), .rst_n(rst_n), .RGB_R(r1), .RGB_G(g1), .RGB_B(b1), .LED(led1));
  processor_top #(.PWM_BITS(8), .STEP_DIV(4), .BLINK_DIV(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .RGB_R(r4), .RGB_G(g4), .RGB_B(b4), .LED(led4));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask
  // 128 + 127*sin(2*pi*p/256), magnitude rounded half up
  function automatic int s_ref(input int p);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
    return x >= 0.0 ? 128 + int'($floor(x + 0.5)) : 128 - int'($floor(0.5 - x));
  endfunction
  task automatic push_exp(input int np);
    for (int k = 0; k < np; k++) begin
      exp_t e;
      int p;
      p = k % 256;
      e.r = s_ref(p);
      e.g = s_ref((p + 64) % 256);
      e.b = s_ref((p + 192) % 256);
      q1.push_back(e);
      q4.push_back(s_ref((k / 4) % 256));
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r"}, int'(r1), 1);
    chk({tag, "_g"}, int'(g1), 1);
    chk({tag, "_b"}, int'(b1), 1);
    chk({tag, "_led"}, int'(led1), 0);
    chk({tag, "_r4"}, int'(r4), 1);
    chk({tag, "_led4"}, int'(led4), 0);
  endtask
  // monitor: windows of 256 samples starting one edge after each period start
  initial begin
    int n, lr, lg, lb, l4, rise4, ledtog;
    logic prev4, prevled;
    n = 0; lr = 0; lg = 0; lb = 0; l4 = 0; rise4 = 0; ledtog = 0;
    prev4 = 1'b1; prevled = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        n = 0; lr = 0; lg = 0; lb = 0; l4 = 0; rise4 = 0; ledtog = 0;
        prev4 = r4; prevled = led1;
      end else begin
        n++;
        lr += int'(!r1);
        lg += int'(!g1);
        lb += int'(!b1);
        l4 += int'(!r4);
        if (prev4 === 1'b0 && r4 === 1'b1) rise4++;
        prev4 = r4;
        if (led1 !== prevled) ledtog++;
        prevled = led1;
        if (n == 1023 || n == 1024 || n == 2047 || n == 2048) chk("led_edge", int'(led1), (n / 1024) % 2);
        if (n == 5000) chk("led_toggles_5000", ledtog, 4);
        if (n <= 40) chk("led4_blink", int'(led4), (n / 5) % 2);
        if (n % 256 == 0) begin
          if (q1.size() == 0 || q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow got %0d want >0 at n=%0d", q1.size(), n);
          end else begin
            exp_t e;
            int e4;
            e = q1.pop_front();
            e4 = q4.pop_front();
            chk($sformatf("dR_p%0d", n / 256 - 1), lr, e.r);
            chk($sformatf("dG_p%0d", n / 256 - 1), lg, e.g);
            chk($sformatf("dB_p%0d", n / 256 - 1), lb, e.b);
            chk($sformatf("div4_dR_p%0d", n / 256 - 1), l4, e4);
            chk($sformatf("div4_offedges_p%0d", n / 256 - 1), rise4, 1);
          end
          lr = 0; lg = 0; lb = 0; l4 = 0; rise4 = 0;
        end
      end
    end
  end
  initial begin
    repeat (5) @(posedge clk);
    #2;
    chk_reset_outputs("reset_hold");
    push_exp(NP1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NP1 * 256) @(posedge clk);
    #2;
    chk("run1_drained", q1.size() + q4.size(), 0);
    repeat ($urandom_range(1, 200)) @(posedge clk);
    #(2 + $urandom_range(0, 5));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    q1.delete();
    q4.delete();
    push_exp(NP2);
    rst_n = 1'b1;
    repeat (NP2 * 256) @(posedge clk);
    #2;
    chk("run2_drained", q1.size() + q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
